// File: rtl/data_memory_controller_pkg.sv
// Shared types and byte-lane helpers for the data memory controller.
// Lane helpers assume four byte lanes in a 32-bit word.
package data_memory_controller_pkg;

    typedef enum logic [1:0] {
        Byte     = 2'd0,
        Half     = 2'd1,
        Word     = 2'd2,
        Reserved = 2'd3
    } AccessSize;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Access  = 2'd1,
        Respond = 2'd2
    } ControllerState;

    // Bits needed to hold the value itself, so an address equal to the depth stays representable.
    function automatic int GetMinWidth(input int value);
        return $clog2(value + 1);
    endfunction

    function automatic logic [31:0] LaneMask(input AccessSize size, input logic [1:0] offset);
        case (size)
            Byte:    return 32'h0000_00FF << {offset, 3'b000};
            Half:    return 32'h0000_FFFF << {offset[1], 4'b0000};
            Word:    return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] LaneReplicate(input AccessSize size, input logic [31:0] data);
        case (size)
            Byte:    return {4{data[7:0]}};
            Half:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] LaneExtract(input AccessSize size, input logic [1:0] offset,
                                                input logic isSigned, input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (size)
            Byte:    return {{24{isSigned & shifted[7]}}, shifted[7:0]};
            Half:    return {{16{isSigned & shifted[15]}}, shifted[15:0]};
            Word:    return word;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic LaneError(input AccessSize size, input logic [1:0] offset);
        case (size)
            Byte:    return 1'b0;
            Half:    return offset[0];
            Word:    return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// Requester handshake plus memory-side bus of the data memory controller.
// The controller takes the slave modport; clients and the memory model take master.
interface data_memory_controller_if #(
    parameter int BitWidth      = 32,
    parameter int Requesters    = 2,
    parameter int ByteAddrWidth = 10,
    parameter int MemAddrWidth  = 8
);
    logic [Requesters-1:0]                    reqValid;
    logic [Requesters-1:0]                    reqReady;
    logic [Requesters-1:0]                    reqWrite;
    logic [Requesters-1:0][1:0]               reqSize;
    logic [Requesters-1:0]                    reqSigned;
    logic [Requesters-1:0][ByteAddrWidth-1:0] reqAddr;
    logic [Requesters-1:0][BitWidth-1:0]      reqWData;
    logic [Requesters-1:0]                    respValid;
    logic [BitWidth-1:0]                      respRData;
    logic                                     respError;
    logic                                     memEnable;
    logic                                     memWrite;
    logic [MemAddrWidth-1:0]                  memAddr;
    logic [BitWidth-1:0]                      memWData;
    logic [BitWidth-1:0]                      memWDataMask;
    logic [BitWidth-1:0]                      memRData;

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memRData,
        input  reqReady, respValid, respRData, respError,
               memEnable, memWrite, memAddr, memWData, memWDataMask
    );

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memRData,
        output reqReady, respValid, respRData, respError,
               memEnable, memWrite, memAddr, memWData, memWDataMask
    );
endinterface

// File: rtl/data_memory_controller_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the pointer, wrapping around.
module data_memory_controller_arbiter #(
    parameter int Requesters = 2
) (
    input  logic [Requesters-1:0]         request,
    input  logic [$clog2(Requesters)-1:0] pointer,
    output logic [Requesters-1:0]         grant,
    output logic [$clog2(Requesters)-1:0] index,
    output logic                          valid
);
    localparam int IndexWidth = $clog2(Requesters);

    logic [IndexWidth-1:0] candidate;

    always_comb begin
        grant     = '0;
        index     = '0;
        valid     = 1'b0;
        candidate = '0;
        for (int k = 0; k < Requesters; k++) begin
            candidate = IndexWidth'((int'(pointer) + k) % Requesters);
            if (!valid && request[candidate]) begin
                valid            = 1'b1;
                index            = candidate;
                grant[candidate] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/data_memory_controller.sv
// Shares the single-port data memory between requesters: round-robin grant, lane translation,
// alignment/range checking and load extension, one request every three cycles.
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int BitWidth   = 32,
    parameter int Capacity   = 128,
    parameter int Requesters = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    data_memory_controller_if.slave bus
);
    localparam int MemAddrWidth  = GetMinWidth(Capacity);
    localparam int ByteAddrWidth = MemAddrWidth + 2;
    localparam int IndexWidth    = $clog2(Requesters);

    ControllerState          state;
    logic [IndexWidth-1:0]   rrPointer;
    logic [IndexWidth-1:0]   grantIndex;
    logic [IndexWidth-1:0]   activeIndex;
    logic [Requesters-1:0]   grant;
    logic                    anyValid;

    AccessSize               selSize;
    logic [1:0]              selOffset;
    logic [MemAddrWidth-1:0] selWordAddr;
    logic                    selError;

    logic                    activeWrite;
    logic                    activeSigned;
    AccessSize               activeSize;
    logic [1:0]              activeOffset;
    logic                    activeError;

    logic                    memEnableQ;
    logic                    memWriteQ;
    logic [MemAddrWidth-1:0] memAddrQ;
    logic [BitWidth-1:0]     memWDataQ;
    logic [BitWidth-1:0]     memMaskQ;
    logic [Requesters-1:0]   respValidQ;
    logic [BitWidth-1:0]     respRDataQ;
    logic                    respErrorQ;

    data_memory_controller_arbiter #(.Requesters(Requesters)) arbiter (
        .request (bus.reqValid),
        .pointer (rrPointer),
        .grant   (grant),
        .index   (grantIndex),
        .valid   (anyValid)
    );

    always_comb begin
        selSize     = AccessSize'(bus.reqSize[grantIndex]);
        selOffset   = bus.reqAddr[grantIndex][1:0];
        selWordAddr = bus.reqAddr[grantIndex][ByteAddrWidth-1:2];
        selError    = LaneError(selSize, selOffset) || (selWordAddr >= MemAddrWidth'(Capacity));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= Idle;
            rrPointer    <= '0;
            activeIndex  <= '0;
            activeWrite  <= 1'b0;
            activeSigned <= 1'b0;
            activeSize   <= Byte;
            activeOffset <= 2'b00;
            activeError  <= 1'b0;
            memEnableQ   <= 1'b0;
            memWriteQ    <= 1'b0;
            memAddrQ     <= '0;
            memWDataQ    <= '0;
            memMaskQ     <= '0;
            respValidQ   <= '0;
            respRDataQ   <= '0;
            respErrorQ   <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    if (anyValid) begin
                        activeIndex  <= grantIndex;
                        activeWrite  <= bus.reqWrite[grantIndex];
                        activeSigned <= bus.reqSigned[grantIndex];
                        activeSize   <= selSize;
                        activeOffset <= selOffset;
                        activeError  <= selError;
                        // Illegal requests never touch the memory bus.
                        if (!selError) begin
                            memEnableQ <= 1'b1;
                            memWriteQ  <= bus.reqWrite[grantIndex];
                            memAddrQ   <= selWordAddr;
                            memWDataQ  <= LaneReplicate(selSize, bus.reqWData[grantIndex]);
                            memMaskQ   <= LaneMask(selSize, selOffset);
                        end
                        state <= Access;
                    end
                end
                Access: begin
                    memEnableQ <= 1'b0;
                    memWriteQ  <= 1'b0;
                    memAddrQ   <= '0;
                    memWDataQ  <= '0;
                    memMaskQ   <= '0;
                    respValidQ <= Requesters'(1) << activeIndex;
                    respErrorQ <= activeError;
                    respRDataQ <= (activeError || activeWrite) ? '0
                                : LaneExtract(activeSize, activeOffset, activeSigned, bus.memRData);
                    state      <= Respond;
                end
                Respond: begin
                    respValidQ <= '0;
                    respRDataQ <= '0;
                    respErrorQ <= 1'b0;
                    rrPointer  <= (activeIndex == IndexWidth'(Requesters - 1)) ? '0 : activeIndex + 1'b1;
                    state      <= Idle;
                end
                default: state <= Idle;
            endcase
        end
    end

    // Reset forces every output low at once so an in-flight store cannot commit.
    assign bus.reqReady     = (state == Idle && !reset) ? grant : '0;
    assign bus.respValid    = reset ? '0 : respValidQ;
    assign bus.respRData    = reset ? '0 : respRDataQ;
    assign bus.respError    = respErrorQ & ~reset;
    assign bus.memEnable    = memEnableQ & ~reset;
    assign bus.memWrite     = memWriteQ & ~reset;
    assign bus.memAddr      = reset ? '0 : memAddrQ;
    assign bus.memWData     = reset ? '0 : memWDataQ;
    assign bus.memWDataMask = reset ? '0 : memMaskQ;
endmodule

// File: tb/tb_data_memory_controller.sv
// Directed scoreboard bench for the data memory controller with a behavioural word memory.
module tb_data_memory_controller;

    localparam int Requesters = 2;
    localparam int Capacity   = 128;
    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;
    localparam logic [1:0] SzRes  = 2'd3;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } Expect;

    logic  clock;
    logic  reset;
    int    testsRun;
    int    testsFailed;
    Expect scoreboard[$];
    logic [31:0] memory [Capacity] = '{default: 32'h0};

    data_memory_controller_if #(
        .BitWidth(32), .Requesters(Requesters), .ByteAddrWidth(10), .MemAddrWidth(8)
    ) bus ();

    data_memory_controller #(
        .BitWidth(32), .Capacity(Capacity), .Requesters(Requesters)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural single-port memory: masked write on the edge, combinational read.
    always @(posedge clock) begin
        if (bus.memEnable && bus.memWrite && bus.memAddr < 8'd128)
            memory[bus.memAddr[6:0]] <= (memory[bus.memAddr[6:0]] & ~bus.memWDataMask)
                                      | (bus.memWData & bus.memWDataMask);
    end
    assign bus.memRData = (bus.memEnable && !bus.memWrite && bus.memAddr < 8'd128)
                        ? memory[bus.memAddr[6:0]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic wr, input logic [1:0] size,
                                 input logic sgn, input logic [9:0] addr, input logic [31:0] wdata);
        bus.reqWrite[port]  = wr;
        bus.reqSize[port]   = size;
        bus.reqSigned[port] = sgn;
        bus.reqAddr[port]   = addr;
        bus.reqWData[port]  = wdata;
        bus.reqValid[port]  = 1'b1;
    endtask

    // Either a response is due (pop and compare) or the response bus must be idle.
    task automatic checkOutput(input string tag, input bit expectResp);
        Expect e;
        if (expectResp) begin
            if (scoreboard.size() == 0) begin
                check({tag, ".sbEmpty"}, 32'(scoreboard.size()), 32'd1);
            end else begin
                e = scoreboard.pop_front();
                check({tag, ".respValid"}, 32'(bus.respValid), 32'(1) << e.port);
                check({tag, ".rData"}, bus.respRData, e.data);
                check({tag, ".error"}, 32'(bus.respError), 32'(e.err));
            end
        end else begin
            check({tag, ".noResp"}, 32'(bus.respValid), 32'd0);
            check({tag, ".rDataIdle"}, bus.respRData, 32'd0);
        end
    endtask

    task automatic runAccess(input string tag, input int port, input logic wr, input logic [1:0] size,
                             input logic sgn, input logic [9:0] addr, input logic [31:0] wdata,
                             input logic [31:0] expData, input logic expErr,
                             input logic [31:0] expMask, input logic [31:0] expWData);
        Expect e;
        int    waited;
        @(negedge clock);
        applyStimulus(port, wr, size, sgn, addr, wdata);
        #1;
        waited = 0;
        while (!bus.reqReady[port] && waited < 10) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check({tag, ".accept"}, 32'(bus.reqReady), 32'(1) << port);
        if (!bus.reqReady[port]) begin
            bus.reqValid[port] = 1'b0;
            return;
        end
        check({tag, ".idleMem"}, 32'(bus.memEnable), 32'd0);
        e.port = port;
        e.data = expErr ? 32'h0 : expData;
        e.err  = expErr;
        scoreboard.push_back(e);

        @(negedge clock);
        #1;
        bus.reqValid[port] = 1'b0;
        check({tag, ".readyLow"}, 32'(bus.reqReady), 32'd0);
        check({tag, ".memEnable"}, 32'(bus.memEnable), 32'(!expErr));
        if (!expErr) begin
            check({tag, ".memAddr"}, 32'(bus.memAddr), 32'(addr[9:2]));
            check({tag, ".memWrite"}, 32'(bus.memWrite), 32'(wr));
            if (wr) begin
                check({tag, ".mask"}, bus.memWDataMask, expMask);
                check({tag, ".wData"}, bus.memWData, expWData);
            end
        end

        @(negedge clock);
        #1;
        checkOutput({tag, ".resp"}, 1'b1);
        check({tag, ".memOff"}, 32'(bus.memEnable), 32'd0);

        @(negedge clock);
        #1;
        checkOutput({tag, ".after"}, 1'b0);
    endtask

    initial begin
        Expect e;
        logic [1:0] expReady;
        testsRun    = 0;
        testsFailed = 0;
        bus.reqValid  = '0;
        bus.reqWrite  = '0;
        bus.reqSize   = '0;
        bus.reqSigned = '0;
        bus.reqAddr   = '0;
        bus.reqWData  = '0;

        // Reset with both clients requesting: everything must stay quiet.
        reset = 1'b1;
        bus.reqValid = 2'b11;
        repeat (3) @(negedge clock);
        #1;
        check("reset.reqReady", 32'(bus.reqReady), 32'd0);
        check("reset.respValid", 32'(bus.respValid), 32'd0);
        check("reset.respRData", bus.respRData, 32'd0);
        check("reset.respError", 32'(bus.respError), 32'd0);
        check("reset.memEnable", 32'(bus.memEnable), 32'd0);
        check("reset.memWrite", 32'(bus.memWrite), 32'd0);
        check("reset.memAddr", 32'(bus.memAddr), 32'd0);
        check("reset.memWData", bus.memWData, 32'd0);
        check("reset.memMask", bus.memWDataMask, 32'd0);
        bus.reqValid = 2'b00;
        @(negedge clock);
        reset = 1'b0;

        // Word, byte and half accesses on word 4.
        runAccess("sw10", 0, 1'b1, SzWord, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hDEADBEEF);
        runAccess("lw10", 0, 1'b0, SzWord, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
        runAccess("sb13", 0, 1'b1, SzByte, 1'b0, 10'h013, 32'h0000007F, 32'h0, 1'b0, 32'hFF000000, 32'h7F7F7F7F);
        runAccess("lb13", 0, 1'b0, SzByte, 1'b1, 10'h013, 32'h0, 32'h0000007F, 1'b0, 32'h0, 32'h0);
        runAccess("sb12", 0, 1'b1, SzByte, 1'b0, 10'h012, 32'h00000080, 32'h0, 1'b0, 32'h00FF0000, 32'h80808080);
        runAccess("lb12", 0, 1'b0, SzByte, 1'b1, 10'h012, 32'h0, 32'hFFFFFF80, 1'b0, 32'h0, 32'h0);
        runAccess("lbu12", 0, 1'b0, SzByte, 1'b0, 10'h012, 32'h0, 32'h00000080, 1'b0, 32'h0, 32'h0);
        runAccess("lh12", 0, 1'b0, SzHalf, 1'b1, 10'h012, 32'h0, 32'h00007F80, 1'b0, 32'h0, 32'h0);
        runAccess("lh10", 0, 1'b0, SzHalf, 1'b1, 10'h010, 32'h0, 32'hFFFFBEEF, 1'b0, 32'h0, 32'h0);
        runAccess("lhu10", 0, 1'b0, SzHalf, 1'b0, 10'h010, 32'h0, 32'h0000BEEF, 1'b0, 32'h0, 32'h0);

        // Second client: upper half store then word read-back.
        runAccess("sh16", 1, 1'b1, SzHalf, 1'b0, 10'h016, 32'h1234C0DE, 32'h0, 1'b0, 32'hFFFF0000, 32'hC0DEC0DE);
        runAccess("lw14", 1, 1'b0, SzWord, 1'b0, 10'h014, 32'h0, 32'hC0DE0000, 1'b0, 32'h0, 32'h0);

        // Error cases, including a misaligned store that must leave word 4 alone.
        runAccess("lw11", 0, 1'b0, SzWord, 1'b0, 10'h011, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
        runAccess("lh13", 1, 1'b0, SzHalf, 1'b1, 10'h013, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
        runAccess("size3", 0, 1'b0, SzRes, 1'b0, 10'h010, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
        runAccess("lw200", 1, 1'b0, SzWord, 1'b0, 10'h200, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
        runAccess("sh11", 0, 1'b1, SzHalf, 1'b0, 10'h011, 32'h0000FFFF, 32'h0, 1'b1, 32'h0, 32'h0);
        runAccess("lw1FC", 1, 1'b0, SzWord, 1'b0, 10'h1FC, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Reset lands during the access cycle of a store: nothing may commit or respond.
        @(negedge clock);
        applyStimulus(0, 1'b1, SzWord, 1'b0, 10'h020, 32'h00001234);
        #1;
        check("abort.accept", 32'(bus.reqReady), 32'd1);
        @(negedge clock);
        #1;
        bus.reqValid = 2'b00;
        check("abort.accessStarted", 32'(bus.memEnable), 32'd1);
        reset = 1'b1;
        #1;
        check("abort.memEnable", 32'(bus.memEnable), 32'd0);
        check("abort.memWrite", 32'(bus.memWrite), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("abort.quiet%0d", i), 1'b0);
            @(negedge clock);
        end

        // Both clients hold loads continuously; grants alternate from pointer 0.
        applyStimulus(0, 1'b0, SzWord, 1'b0, 10'h010, 32'h0);
        applyStimulus(1, 1'b0, SzWord, 1'b0, 10'h014, 32'h0);
        for (int c = 0; c < 12; c++) begin
            #1;
            expReady = (c % 3 == 0) ? 2'(1 << ((c / 3) % 2)) : 2'b00;
            check($sformatf("rr.ready%0d", c), 32'(bus.reqReady), 32'(expReady));
            if (expReady != 2'b00) begin
                e.port = (c / 3) % 2;
                e.data = (e.port == 0) ? 32'h7F80BEEF : 32'hC0DE0000;
                e.err  = 1'b0;
                scoreboard.push_back(e);
            end
            checkOutput($sformatf("rr.cycle%0d", c), c % 3 == 2);
            @(negedge clock);
        end
        bus.reqValid = 2'b00;
        repeat (3) @(negedge clock);

        runAccess("lw20", 0, 1'b0, SzWord, 1'b0, 10'h020, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

        check("sb.drained", 32'(scoreboard.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
